chan_buffer_bank: RTL

CHAN_BUFFER_BANK -- requirements
Module: chan_buffer_bank

---
 rtl/buf_pkg.sv | 38 +++
 rtl/chan_fifo.sv | 108 ++++++++++
 rtl/chan_buffer_bank.sv | 57 +++++
 3 files changed

// File: rtl/buf_pkg.sv
// Shared constants and helpers for the channel buffer bank.
package buf_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_DEPTH     = 6;
  localparam int DEF_PAYLOAD_W = 2;
  localparam int DEF_OVERWRITE = 1;

  localparam int MAX_PAYLOAD_W = 32;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSH_POP,
    OP_OVERWRITE,
    OP_DROP
  } fifo_op_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Slot image is {payload, valid}; callers truncate to PAYLOAD_W+1 bits.
  function automatic logic [MAX_PAYLOAD_W:0] pack_slot(input logic [MAX_PAYLOAD_W-1:0] payload,
                                                       input logic valid);
    return {payload, valid};
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-channel circular buffer with per-slot valid bits and sticky error flags.
module chan_fifo
  import buf_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int OVERWRITE = DEF_OVERWRITE,
  localparam int PTR_W    = clog2(DEPTH),
  localparam int CNT_W    = clog2(DEPTH + 1),
  localparam int SLOT_W   = PAYLOAD_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [PAYLOAD_W-1:0]    push_data,
  input  logic                    pop,
  output logic [PAYLOAD_W-1:0]    head,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH*SLOT_W-1:0] snap,
  output logic                    ovf,
  output logic                    udf
);

  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [PTR_W-1:0]     wptr_q;
  logic [PTR_W-1:0]     rptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic                 udf_q;
  fifo_op_e             op;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    op = OP_IDLE;
    if (push && pop) begin
      op = empty ? OP_PUSH : OP_PUSH_POP;
    end else if (push) begin
      if (!full)              op = OP_PUSH;
      else if (OVERWRITE != 0) op = OP_OVERWRITE;
      else                    op = OP_DROP;
    end else if (pop && !empty) begin
      op = OP_POP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pay_q[i] <= '0;
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          pay_q[wptr_q] <= push_data;
          vld_q[wptr_q] <= 1'b1;
          wptr_q        <= next_ptr(wptr_q);
          cnt_q         <= cnt_q + CNT_W'(1);
        end
        OP_POP: begin
          vld_q[rptr_q] <= 1'b0;
          rptr_q        <= next_ptr(rptr_q);
          cnt_q         <= cnt_q - CNT_W'(1);
        end
        // When full, wptr equals rptr: the later set must win so the new slot stays valid.
        OP_PUSH_POP: begin
          vld_q[rptr_q] <= 1'b0;
          pay_q[wptr_q] <= push_data;
          vld_q[wptr_q] <= 1'b1;
          wptr_q        <= next_ptr(wptr_q);
          rptr_q        <= next_ptr(rptr_q);
        end
        OP_OVERWRITE: begin
          pay_q[wptr_q] <= push_data;
          vld_q[wptr_q] <= 1'b1;
          wptr_q        <= next_ptr(wptr_q);
          rptr_q        <= next_ptr(rptr_q);
        end
        default: ;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
      if (pop && empty)         udf_q <= 1'b1;
    end
  end

  assign head  = empty ? '0 : pay_q[rptr_q];
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  for (genvar s = 0; s < DEPTH; s++) begin : g_snap
    assign snap[s*SLOT_W +: SLOT_W] =
      (SLOT_W)'(pack_slot((MAX_PAYLOAD_W)'(pay_q[s]), vld_q[s]));
  end

endmodule

// File: rtl/chan_buffer_bank.sv
// Bank of independent per-channel buffers; the push channel is taken from the top bits of in_data.
module chan_buffer_bank
  import buf_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int OVERWRITE = DEF_OVERWRITE,
  localparam int CH_W     = clog2(NUM_CH),
  localparam int CNT_W    = clog2(DEPTH + 1),
  localparam int SLOT_W   = PAYLOAD_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [CH_W+PAYLOAD_W-1:0]        in_data,
  input  logic [NUM_CH-1:0]                pop,
  output logic [NUM_CH*PAYLOAD_W-1:0]      head_o,
  output logic [NUM_CH*CNT_W-1:0]          count_o,
  output logic [NUM_CH-1:0]                full_o,
  output logic [NUM_CH-1:0]                empty_o,
  output logic [NUM_CH*DEPTH*SLOT_W-1:0]   snap_o,
  output logic [NUM_CH-1:0]                ovf_o,
  output logic [NUM_CH-1:0]                udf_o
);

  logic [CH_W-1:0]      sel_ch;
  logic [PAYLOAD_W-1:0] payload;

  assign sel_ch  = in_data[PAYLOAD_W +: CH_W];
  assign payload = in_data[PAYLOAD_W-1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic push_ch;
    assign push_ch = in_valid && (sel_ch == CH_W'(c));

    chan_fifo #(
      .DEPTH    (DEPTH),
      .PAYLOAD_W(PAYLOAD_W),
      .OVERWRITE(OVERWRITE)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_ch),
      .push_data(payload),
      .pop      (pop[c]),
      .head     (head_o[c*PAYLOAD_W +: PAYLOAD_W]),
      .count    (count_o[c*CNT_W +: CNT_W]),
      .full     (full_o[c]),
      .empty    (empty_o[c]),
      .snap     (snap_o[c*DEPTH*SLOT_W +: DEPTH*SLOT_W]),
      .ovf      (ovf_o[c]),
      .udf      (udf_o[c])
    );
  end

endmodule
